// File: rtl/uart_mmio_pkg.sv
// Shared constants for uart_mmio: register offsets, STATUS bit positions,
// TX/RX FSM state encodings and the baud divisor floor.
package uart_mmio_pkg;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_RXDATA  = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_BAUDDIV = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_OVERRUN   = 5;
  localparam int ST_FRAME_ERR = 6;

  localparam logic [15:0] UART_MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < UART_MIN_DIV) ? UART_MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo.sv
// uart_fifo: synchronous FIFO with combinational head; pop on empty is ignored,
// push on full is ignored unless a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == FULL_CNT);
  assign head_o  = r_mem[r_rptr];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: bus-mapped 8N1 UART, zero-wait loads, side effects at the access edge; full TX FIFO
// drops stores, full RX FIFO drops bytes (overrun). RX path built only when UART_RX_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic        wmem_en_i,
  input  logic        rmem_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o
);

  logic [1:0]  w_sel;
  logic        w_wr, w_rd, w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_tick, w_tx_busy;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [15:0] r_div, r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic        w_rx_empty, w_rx_full, w_overrun, w_frame_err;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_sel     = mem_addr_i[3:2];
  assign w_wr      = cs_i & wmem_en_i;
  assign w_rd      = cs_i & rmem_en_i;
  assign w_tx_push = w_wr && (w_sel == UART_TXDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= 16'(DEFAULT_DIV);
    else if (w_wr && (w_sel == UART_BAUDDIV)) r_div <= clamp_div(mem_data_i[15:0]);
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(w_tx_push), .pop_i(w_tx_pop), .data_i(mem_data_i[7:0]),
    .full_o(w_tx_full), .empty_o(w_tx_empty), .head_o(w_tx_head)
  );

  assign w_tx_tick = (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_busy = (r_tx_state != TX_IDLE);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (!w_tx_empty) begin
                  w_tx_state_nxt = TX_START;
                  w_tx_pop       = 1'b1;
                end
      TX_START: if (w_tx_tick) w_tx_state_nxt = TX_DATA;
      TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_state_nxt = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
                  // Chain straight into the next frame when more data is queued.
                  w_tx_state_nxt = w_tx_empty ? TX_IDLE : TX_START;
                  w_tx_pop       = !w_tx_empty;
                end
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= 16'(DEFAULT_DIV);
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_div   <= r_div;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
      end else if (w_tx_busy) begin
        if (w_tx_tick) begin
          r_tx_cnt <= '0;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  assign uart_txd_o = (r_tx_state == TX_START) ? 1'b0 :
                      (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

`ifdef UART_RX_EN
  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [1:0]  r_rx_sync;
  logic        r_rx_prev, r_overrun, r_frame_err;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_line, w_rx_fall, w_rx_tick, w_rx_done, w_rx_push, w_rx_pop, w_w1c;

  assign w_rx_line = r_rx_sync[1];
  assign w_rx_fall = r_rx_prev & ~w_rx_line;
  // START waits half a bit so every later sample lands mid-bit.
  assign w_rx_tick = (r_rx_state == RX_START) ? (r_rx_cnt == (r_rx_div >> 1) - 16'd1)
                                              : (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_pop  = w_rd && (w_sel == UART_RXDATA) && !w_rx_empty;
  assign w_rx_push = w_rx_done & w_rx_line;
  assign w_w1c     = w_wr && (w_sel == UART_STATUS);

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_state_nxt = w_rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
                  w_rx_state_nxt = RX_IDLE;
                  w_rx_done      = 1'b1;
                end
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync   <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_div    <= 16'(DEFAULT_DIV);
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_rxd_i};
      r_rx_prev  <= w_rx_line;
      r_rx_state <= w_rx_state_nxt;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= '0;
        r_rx_bit <= '0;
        r_rx_div <= r_div;
      end else if (w_rx_tick) begin
        r_rx_cnt <= '0;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
      r_overrun   <= (w_rx_push & w_rx_full & ~w_rx_pop) |
                     (r_overrun & ~(w_w1c & mem_data_i[ST_OVERRUN]));
      r_frame_err <= (w_rx_done & ~w_rx_line) |
                     (r_frame_err & ~(w_w1c & mem_data_i[ST_FRAME_ERR]));
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(w_rx_push), .pop_i(w_rx_pop), .data_i(r_rx_shift),
    .full_o(w_rx_full), .empty_o(w_rx_empty), .head_o(w_rx_head)
  );

  assign w_overrun   = r_overrun;
  assign w_frame_err = r_frame_err;
  assign w_unused    = ^{mem_addr_i[31:4], mem_addr_i[1:0], mem_data_i[31:16]};
`else
  assign w_rx_empty  = 1'b1;
  assign w_rx_full   = 1'b0;
  assign w_rx_head   = 8'h00;
  assign w_overrun   = 1'b0;
  assign w_frame_err = 1'b0;
  assign w_unused    = ^{mem_addr_i[31:4], mem_addr_i[1:0], mem_data_i[31:16], uart_rxd_i};
`endif

  always_comb begin
    w_status               = '0;
    w_status[ST_TX_FULL]   = w_tx_full;
    w_status[ST_TX_EMPTY]  = w_tx_empty;
    w_status[ST_RX_VALID]  = !w_rx_empty;
    w_status[ST_RX_FULL]   = w_rx_full;
    w_status[ST_TX_BUSY]   = w_tx_busy;
    w_status[ST_OVERRUN]   = w_overrun;
    w_status[ST_FRAME_ERR] = w_frame_err;
  end

  always_comb begin
    mem_data_o = '0;
    if (w_rd) begin
      case (w_sel)
        UART_RXDATA:  if (!w_rx_empty) mem_data_o = {24'h0, w_rx_head};
        UART_STATUS:  mem_data_o = w_status;
        UART_BAUDDIV: mem_data_o = {16'h0, r_div};
        default:      mem_data_o = '0;
      endcase
    end
  end

endmodule
